// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and the FIFO operation encoding used by the
// receive-side buffering logic.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_DATA_WIDTH      = 8;
  localparam int unsigned UART_FIFO_ADDR_WIDTH = 4;

  // Effective FIFO operation on a clock edge, packed as {pop, push}.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO: storage, wrapping pointers and
// occupancy count. A push is refused when full unless a pop happens on the
// same edge; a pop is ignored when empty.
module sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;

  logic     push_ok;
  logic     pop_ok;
  fifo_op_e op;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointer/count state.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    op       = fifo_op_e'({pop_ok, push_ok});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (op)
      FIFO_PUSH: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_q + CNT_ONE;
      end
      FIFO_POP: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - CNT_ONE;
      end
      FIFO_BOTH: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      default: ;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: turns the byte-ready level into a
// single push per rising edge, buffers bytes in a FWFT FIFO, and keeps a
// sticky flag for bytes lost to a full FIFO.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  logic rx_ready_q, rx_ready_d;
  logic overflow_q, overflow_d;
  logic push_stb;
  logic pop;
  logic drop;
  logic empty;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_stb),
    .pop   (pop),
    .din   (rx_data),
    .dout  (m_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign m_valid  = ~empty;
  assign overflow = overflow_q;

  // Edge-detect rx_ready and derive push/pop/drop; a set overrides a clear.
  always_comb begin
    rx_ready_d = rx_ready;
    push_stb   = rx_ready & ~rx_ready_q;
    pop        = m_valid & m_ready;
    drop       = push_stb & full & ~pop;
    overflow_d = overflow_q;
    if (overflow_clear) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // rx_ready history resets high so a level held through reset is not a push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning byte width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning log2 of FIFO depth (16 entries).
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 The block SHALL have port rx_data, input, DATA_WIDTH, meaning the received byte from the UART receiver.
REQ-006 The block SHALL have port rx_ready, input, 1, meaning the byte-ready level from the receiver; it may stay high for many clk cycles.
REQ-007 The block SHALL have port m_data, output, DATA_WIDTH, meaning the head-of-FIFO byte.
REQ-008 The block SHALL have port m_valid, output, 1, meaning m_data holds a valid byte.
REQ-009 The block SHALL have port m_ready, input, 1, meaning the consumer accepts m_data this cycle.
REQ-010 The block SHALL have port count, output, ADDR_WIDTH+1, meaning the number of stored bytes (0..16).
REQ-011 The block SHALL have port full, output, 1, meaning count equals the depth.
REQ-012 The block SHALL have port overflow, output, 1, meaning sticky lost-byte flag.
REQ-013 The block SHALL have port overflow_clear, input, 1, meaning a synchronous clear of overflow.

Function
REQ-014 The block SHALL register rx_ready into rx_ready_q every clk; the push strobe SHALL be rx_ready & ~rx_ready_q, giving exactly one push per rx_ready rising edge.
REQ-015 On a push strobe at clk edge k, the block SHALL write rx_data into storage and SHALL raise m_valid after edge k (1-cycle latency).
REQ-016 The FIFO SHALL be first-word-fall-through: m_data SHALL equal the oldest stored byte whenever m_valid=1, and m_valid SHALL equal (count != 0).
REQ-017 A pop SHALL occur on an edge where m_valid & m_ready; m_data and m_valid SHALL be undefined/ignored and no pop SHALL occur while m_valid=0.
REQ-018 Write and read pointers SHALL be ADDR_WIDTH bits and wrap modulo 16; count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-019 A push while full with no pop in the same cycle SHALL drop the byte, leave storage and count unchanged, and set overflow.
REQ-020 A push while full with a simultaneous pop SHALL be accepted; count SHALL stay 16 and overflow SHALL not be set.
REQ-021 A push while empty with m_ready=1 SHALL store the byte; no pop SHALL occur that cycle.
REQ-022 overflow SHALL hold until an edge with overflow_clear=1; if a new overflow and overflow_clear coincide, overflow SHALL end 1 (set wins).
REQ-023 m_ready held high with the FIFO empty SHALL have no effect.

Reset
REQ-024 Asserting reset SHALL asynchronously force: pointers=0, count=0, m_valid=0, full=0, overflow=0, rx_ready_q=1.
REQ-025 rx_ready_q resetting to 1 SHALL suppress a spurious push if rx_ready is high when reset releases; a reset mid-burst SHALL discard all stored bytes.
REQ-026 Storage contents SHALL not be reset; m_data after reset is don't-care.

Structure
REQ-027 Shared constants (UART_DATA_WIDTH=8, UART_FIFO_ADDR_WIDTH=4) SHALL live in the common UART header used by the receiver and transmitter.
REQ-028 Storage and pointer logic SHALL be a sub-module sync_fifo (push, pop, din, dout, count, full, empty); edge detection and the overflow flag SHALL stay in uart_rx_fifo.

Verification
REQ-029 Push 0xA5 with rx_ready held high for 8 cycles -> exactly one entry; count=1; m_valid=1 one cycle after the rising edge; m_data=0xA5.
REQ-030 Push 0x00..0x0F with m_ready=0, then pop all -> full=1 at count=16; bytes return in order 0x00..0x0F; m_valid=0 after the 16th pop.
REQ-031 With the FIFO full, push 0x55 with m_ready=0 -> count stays 16, overflow=1, 0x55 is never output; pulse overflow_clear -> overflow=0.
REQ-032 With the FIFO full, push 0x77 with m_ready=1 on the same edge -> count=16, overflow=0; 0x77 is output 16th after the pop.
REQ-033 Hold rx_ready=1 across reset assertion and release after pushing 3 bytes -> count=0, m_valid=0, no push until rx_ready falls and rises again.
REQ-034 Random pushes and pops for 2000 cycles with pointers wrapping -> output sequence matches a scoreboard and count never exceeds 16.
